// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage for the pipelined core.
//
// Contents:
//   - PC register with next-PC selection: start address, redirect target,
//     or PC+4.
//   - Word-addressed instruction memory. The program loader writes it while
//     the stage is idle; fetch reads it synchronously.
//   - IF/ID output register with valid, stall and flush control.
//
// Optional build macro: FETCH_HALT_DET_EN
//   When this macro is defined, fetching the erased-memory word (all ones)
//   stops the stage in a HALT state. Only reset leaves HALT.
//   When it is undefined, there is no HALT state and o_halted is tied to 0.
//
// Ports:
//   clk            : clock; all logic runs on the rising edge
//   i_rst          : synchronous, active-high reset
//   i_load_we      : loader write strobe (honoured only while idle)
//   i_load_addr    : loader word address
//   i_load_data    : loader write data
//   i_start        : single-cycle pulse that moves IDLE -> RUN
//   i_stall        : hold the PC and the IF/ID register
//   i_redirect     : take a branch/jump and flush the slot in flight
//   i_redirect_pc  : redirect target (low two bits are ignored)
//   o_instr        : IF/ID instruction
//   o_pc           : IF/ID PC of o_instr
//   o_pc_plus4     : o_pc + 4, registered
//   o_valid        : the IF/ID slot holds a live instruction
//   o_running      : the stage is in RUN
//   o_halted       : the stage is in HALT
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                NB_PC           = 32,
    parameter int                NB_INSTR        = 32,
    parameter int                IMEM_ADDR_WIDTH = 10,
    parameter logic [NB_PC-1:0]  RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_load_we,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_load_addr,
    input  logic [NB_INSTR-1:0]        i_load_data,
    input  logic                       i_start,
    input  logic                       i_stall,
    input  logic                       i_redirect,
    input  logic [NB_PC-1:0]           i_redirect_pc,
    output logic [NB_INSTR-1:0]        o_instr,
    output logic [NB_PC-1:0]           o_pc,
    output logic [NB_PC-1:0]           o_pc_plus4,
    output logic                       o_valid,
    output logic                       o_running,
    output logic                       o_halted
);

    localparam int DEPTH = 2 ** IMEM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef FETCH_HALT_DET_EN
        ST_HALT = 2'd2,
`endif
        ST_RUN  = 2'd1
    } state_t;

    state_t                     state_q, state_d;
    logic [NB_PC-1:0]           pc_q, pc_d;
    logic [NB_INSTR-1:0]        instr_q;
    logic [NB_PC-1:0]           opc_q;
    logic [NB_PC-1:0]           pc4_q;
    logic                       valid_q;

    logic [NB_INSTR-1:0]        mem [DEPTH];

    logic                       mem_we;
    logic                       fetch_en;
    logic                       redirect_en;
    logic                       halt_en;
    logic [NB_PC-1:0]           redirect_tgt;
    logic [IMEM_ADDR_WIDTH-1:0] fetch_idx;

    // Clearing the two low bits aligns the redirect target to a word.
    assign redirect_tgt = i_redirect_pc & ~NB_PC'(3);
    // The PC bits above the index are dropped, so fetch wraps modulo depth.
    assign fetch_idx    = pc_q[IMEM_ADDR_WIDTH+1:2];

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_we      = 1'b0;
        fetch_en    = 1'b0;
        redirect_en = 1'b0;
        halt_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A load in the same cycle as start still completes.
                mem_we = i_load_we;
                if (i_start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                // Priority: redirect first, then halt detection, then stall.
                if (i_redirect) begin
                    redirect_en = 1'b1;
                    pc_d        = redirect_tgt;
                end
`ifdef FETCH_HALT_DET_EN
                else if (valid_q && (instr_q == {NB_INSTR{1'b1}})) begin
                    halt_en = 1'b1;
                    state_d = ST_HALT;
                end
`endif
                else if (!i_stall) begin
                    fetch_en = 1'b1;
                    pc_d     = pc_q + NB_PC'(4);
                end
            end
`ifdef FETCH_HALT_DET_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, PC and IF/ID control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            opc_q   <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fetch_en) begin
                opc_q   <= pc_q;
                pc4_q   <= pc_q + NB_PC'(4);
                valid_q <= 1'b1;
            end else if (redirect_en || halt_en) begin
                // The slot is flushed. The old instruction and PC stay visible.
                valid_q <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Instruction memory: write port and output register
    // -------------------------------------------------------------------------
    // Memory contents have no reset and survive i_rst. Writes are blocked
    // while reset is asserted. The output register has a sync reset.
    always_ff @(posedge clk) begin
        if (mem_we && !i_rst) begin
            mem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            instr_q <= '0;
        end else if (fetch_en) begin
            instr_q <= mem[fetch_idx];
        end
    end

    assign o_instr    = instr_q;
    assign o_pc       = opc_q;
    assign o_pc_plus4 = pc4_q;
    assign o_valid    = valid_q;
    assign o_running  = (state_q == ST_RUN);
`ifdef FETCH_HALT_DET_EN
    assign o_halted   = (state_q == ST_HALT);
`else
    assign o_halted   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Testbench for fetch_stage. A transaction-level model holds an array image
// of the instruction memory and the expected IF/ID contents. The model
// advances once per clock edge. At every falling edge the DUT outputs are
// compared against it. Directed steps also check hand-computed literal
// values.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          start;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic          valid;
    logic          running;
    logic          halted;

    fetch_stage #(
        .NB_PC(32), .NB_INSTR(32), .IMEM_ADDR_WIDTH(AW), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .i_rst(rst),
        .i_load_we(load_we), .i_load_addr(load_addr), .i_load_data(load_data),
        .i_start(start), .i_stall(stall),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_instr(instr), .o_pc(pc), .o_pc_plus4(pc_plus4),
        .o_valid(valid), .o_running(running), .o_halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: 0 = idle, 1 = running, 2 = halted.
    logic [31:0] m_mem [DEPTH];
    int          m_st = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] e_instr = 32'h0;
    logic [31:0] e_pc = 32'h0;
    logic [31:0] e_p4 = 32'h0;
    logic        e_valid = 1'b0;

    logic [31:0] prog [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs seen at that edge.
    task automatic model_step();
        if (rst) begin
            m_st = 0; m_pc = 32'h0;
            e_instr = 32'h0; e_pc = 32'h0; e_p4 = 32'h0; e_valid = 1'b0;
        end else if (m_st == 0) begin
            if (load_we) m_mem[load_addr] = load_data;
            if (start) begin m_st = 1; m_pc = 32'h0; end
        end else if (m_st == 1) begin
            if (redirect) begin
                m_pc = (redirect_pc / 4) * 4;
                e_valid = 1'b0;
            end
`ifdef FETCH_HALT_DET_EN
            else if (e_valid && e_instr == 32'hFFFF_FFFF) begin
                m_st = 2;
                e_valid = 1'b0;
            end
`endif
            else if (!stall) begin
                e_instr = m_mem[(m_pc / 4) % DEPTH];
                e_pc    = m_pc;
                e_p4    = m_pc + 32'd4;
                e_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare process: every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        chk("cyc_instr",    instr,           e_instr);
        chk("cyc_pc",       pc,              e_pc);
        chk("cyc_pc_plus4", pc_plus4,        e_p4);
        chk("cyc_valid",    {31'b0, valid},  {31'b0, e_valid});
        chk("cyc_running",  {31'b0, running}, {31'b0, (m_st == 1)});
        chk("cyc_halted",   {31'b0, halted}, {31'b0, (m_st == 2)});
    end

    initial begin
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_running", {31'b0, running}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        rst = 1'b0;

        // Load the whole memory. The last word is loaded together with start.
        for (int i = 0; i < DEPTH; i++) begin
            load_we = 1'b1; load_addr = AW'(i);
            load_data = (i < 4) ? prog[i] : (32'hA500_0000 | i);
            start = (i == DEPTH - 1);
            tick();
        end
        load_we = 1'b0; start = 1'b0;
        chk("start_running", {31'b0, running}, 32'd1);
        chk("start_valid", {31'b0, valid}, 32'd0);

        // Stream
        tick();
        chk("run_pc0", pc, 32'h0);
        chk("run_instr0", instr, 32'h00500093);
        chk("run_p4_0", pc_plus4, 32'h4);
        chk("run_valid0", {31'b0, valid}, 32'd1);
        tick();
        chk("run_pc1", pc, 32'h4);

        // Stall for 3 cycles
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", pc, 32'h4);
            chk("stall_instr", instr, 32'h00A00113);
            chk("stall_valid", {31'b0, valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", pc, 32'h8);
        chk("unstall_instr", instr, 32'h002081B3);

        // Misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h0000_0012;
        tick();
        chk("redir_valid", {31'b0, valid}, 32'd0);
        chk("redir_pc_hold", pc, 32'h8);
        redirect = 1'b0;
        tick();
        chk("redir_tgt_pc", pc, 32'h10);
        chk("redir_tgt_instr", instr, 32'hA500_0004);
        chk("redir_tgt_valid", {31'b0, valid}, 32'd1);

        // Stall together with redirect
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0012;
        tick();
        chk("stredir_valid", {31'b0, valid}, 32'd0);
        stall = 1'b0; redirect = 1'b0;
        tick();
        chk("stredir_pc", pc, 32'h10);
        chk("stredir_valid2", {31'b0, valid}, 32'd1);

        // Back-to-back redirects: the last target wins
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("b2b_valid0", {31'b0, valid}, 32'd0);
        redirect_pc = 32'h20;
        tick();
        chk("b2b_valid1", {31'b0, valid}, 32'd0);
        redirect = 1'b0;
        tick();
        chk("b2b_pc", pc, 32'h20);
        chk("b2b_instr", instr, 32'hA500_0008);

        // Wrap at the top of memory, with loader writes and start ignored in RUN
        redirect = 1'b1; redirect_pc = 32'h0000_0FFC; start = 1'b1;
        tick();
        redirect = 1'b0; start = 1'b0;
        load_we = 1'b1; load_addr = '0; load_data = 32'hDEAD_BEEF;
        tick();
        load_we = 1'b0;
        chk("wrap_pc_top", pc, 32'h0FFC);
        chk("wrap_instr_top", instr, 32'hA500_03FF);
        tick();
        chk("wrap_pc", pc, 32'h1000);
        chk("wrap_instr", instr, 32'h00500093);
        chk("wrap_p4", pc_plus4, 32'h1004);

        // Reset mid-run, then replay the same program
        rst = 1'b1;
        tick();
        chk("mrst_valid", {31'b0, valid}, 32'd0);
        chk("mrst_running", {31'b0, running}, 32'd0);
        chk("mrst_pc", pc, 32'h0);
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("replay_pc0", pc, 32'h0);
        chk("replay_instr0", instr, 32'h00500093);
        tick();
        chk("replay_instr1", instr, 32'h00A00113);

        // Erased word at mem[2]
        rst = 1'b1;
        tick();
        rst = 1'b0; load_we = 1'b1; load_addr = AW'(2); load_data = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        load_we = 1'b0; start = 1'b0;
        tick(); tick(); tick();
        chk("erased_pc", pc, 32'h8);
        chk("erased_instr", instr, 32'hFFFF_FFFF);
        chk("erased_valid", {31'b0, valid}, 32'd1);
        tick();
`ifdef FETCH_HALT_DET_EN
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_valid", {31'b0, valid}, 32'd0);
        chk("halt_pc", pc, 32'h8);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("halt_hold", {31'b0, halted}, 32'd1);
        chk("halt_norun", {31'b0, running}, 32'd0);
`else
        chk("nohalt_pc", pc, 32'hC);
        chk("nohalt_valid", {31'b0, valid}, 32'd1);
        chk("nohalt_halted", {31'b0, halted}, 32'd0);
        tick();
`endif
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined core.
- Contains the PC register, next-PC selection (PC+4 or redirect), a word-addressed instruction memory with a host load port, and the IF/ID output register with valid, stall and flush control.
- Sits between the UART program loader and the decode stage.
- Supersedes the loose PC, adder, mux, memory and IF/ID instances currently wired in the core.

Parameters:
- NB_PC, 32, program counter width.
- NB_INSTR, 32, instruction and memory word width.
- IMEM_ADDR_WIDTH, 10, memory word-address width; depth = 2**IMEM_ADDR_WIDTH words.
- RESET_PC, 0, PC loaded when a run starts.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_load_we  in  1  loader write strobe; honoured only in IDLE.
- i_load_addr  in  IMEM_ADDR_WIDTH  loader word address.
- i_load_data  in  NB_INSTR  loader write data.
- i_start  in  1  single-cycle pulse; IDLE -> RUN.
- i_stall  in  1  hold the PC and the IF/ID register.
- i_redirect  in  1  take a branch/jump; flush the slot in flight.
- i_redirect_pc  in  NB_PC  redirect target.
- o_instr  out  NB_INSTR  IF/ID instruction.
- o_pc  out  NB_PC  IF/ID PC of o_instr.
- o_pc_plus4  out  NB_PC  o_pc + 4, registered.
- o_valid  out  1  IF/ID slot holds a live instruction.
- o_running  out  1  state == RUN.
- o_halted  out  1  state == HALT; tied 0 without the optional feature.

Behaviour:
- Reset (any state, any cycle):
  - State goes to IDLE; pc_q = RESET_PC.
  - o_instr, o_pc, o_pc_plus4 = 0; o_valid = 0; o_running = 0; o_halted = 0.
  - Memory contents are preserved.
- IDLE:
  - i_load_we writes i_load_data to mem[i_load_addr] on the next edge.
  - No fetch; o_valid = 0.
  - i_start moves to RUN and sets pc_q = RESET_PC.
  - i_start together with i_load_we in the same cycle: the write completes, then RUN starts.
- RUN:
  - i_load_we is ignored.
  - i_start is ignored.
- Memory:
  - Synchronous read at word index pc_q[IMEM_ADDR_WIDTH+1:2].
  - PC bits above the index are ignored, so fetch addresses wrap modulo depth.
- Advance (RUN, no stall, no redirect), all on one edge:
  - o_instr = mem[pc_q]; o_pc = pc_q; o_pc_plus4 = pc_q + 4; o_valid = 1.
  - pc_q = pc_q + 4, modulo 2**NB_PC.
  - Fetch-to-o_valid latency is 1 cycle after entering RUN; the first valid slot is RESET_PC.
- Stall (RUN, i_stall=1, i_redirect=0):
  - pc_q, o_instr, o_pc, o_pc_plus4 and o_valid all hold.
  - No memory read enable.
- Redirect (i_redirect=1, RUN; overrides stall):
  - pc_q = {i_redirect_pc[NB_PC-1:2], 2'b00}; misaligned low bits are cleared.
  - o_valid = 0 next cycle; o_instr and o_pc hold their old values.
  - The target instruction appears with o_valid = 1 two edges after the redirect.
- Redirect asserted for consecutive cycles: the last target wins, and o_valid stays 0 throughout.
- i_stall and i_redirect outside RUN: no effect.

Optional Feature:
- Macro: FETCH_HALT_DET_EN.
- Defined:
  - When a word equal to 32'hFFFF_FFFF (erased memory) is fetched, it is presented with o_valid = 1 for that slot.
  - On the next edge: state goes to HALT, o_valid = 0, o_halted = 1, pc_q freezes.
  - The halt word's o_pc stays visible.
  - Only reset leaves HALT; i_start is ignored in HALT.
  - A redirect in the same cycle the halt word is latched wins: no halt.
- Undefined:
  - There is no HALT state; 32'hFFFF_FFFF is fetched as a normal word.
  - o_halted is constant 0.

Test Plan:
- Load and run: load mem[0..3] = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013; pulse i_start -> o_valid rises next edge; o_pc sequence 0, 4, 8, 12 with matching o_instr; o_pc_plus4 = o_pc + 4.
- Stall: assert i_stall 3 cycles while o_pc = 4 -> o_pc = 4, o_instr = 32'h00A00113, o_valid = 1 held for 3 cycles; o_pc = 8 on the first edge after release.
- Redirect: at o_pc = 8, pulse i_redirect with i_redirect_pc = 32'h0000_0012 -> o_valid = 0 for one cycle; next valid o_pc = 32'h10; stall + redirect together behaves identically.
- Wrap and loader lockout: run from 32'h0000_0FFC with IMEM_ADDR_WIDTH = 10 -> next o_pc = 32'h1000 reading mem[0]; i_load_we pulsed during RUN -> memory unchanged.
- Reset mid-run: assert i_rst during streaming -> next edge o_valid = 0, o_running = 0, o_pc = 0; memory intact, so a re-pulsed i_start replays the same program.
- FETCH_HALT_DET_EN: place 32'hFFFF_FFFF at mem[2] -> slot o_pc = 8 valid, then o_halted = 1, o_valid = 0, frozen; i_start ignored; without the macro, o_pc = 12 follows.
